mem_lsu_stage: RTL
==================

Name: mem_lsu_stage

Overview:
- Parametrised successor to the pipeline's memory-access stage for the RISC-V core.
- Accepts one load, store or pass-through op from EX and drives the data-memory port.
- Supports byte/half/word/double sizes with byte strobes and sign/zero extension, plus a configurable fixed memory latency.
- Returns a single-cycle-valid result to WB.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width; legal values are 32 or 64. NB = DATA_W/8 byte lanes; OFS_W = log2(NB).
- MEM_LAT, 1, cycles from request edge to read-data sample edge; must be >= 1.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  op present; accepted only while o_ready=1
- o_ready  out  1  stage idle, can accept an op
- i_addr  in  DATA_W  effective address, or ALU result for pass-through
- i_data  in  DATA_W  store data (rs2)
- i_rd_id  in  5  destination register
- i_type  in  2  0 load, 1 store, 2/3 pass-through
- i_funct3  in  3  size: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 treated as D
- o_data  out  DATA_W  load result, or i_addr for store/pass-through
- o_rd_id  out  5  captured i_rd_id
- o_type  out  2  captured i_type
- o_valid  out  1  result valid, one-cycle pulse
- o_misalign  out  1  misaligned-access flag, qualified by o_valid
- o_d_r_addr  out  ADDR_W  read address, NB-aligned
- o_d_w_addr  out  ADDR_W  write address, NB-aligned
- o_d_w_data  out  DATA_W  lane-shifted store data
- o_d_w_strb  out  NB  byte write enables
- o_d_MemRead  out  1  read request, one-cycle pulse
- o_d_MemWrite  out  1  write request, one-cycle pulse
- i_d_data  in  DATA_W  read data, valid at the sample edge

Behaviour:
- Reset (async, i_rst_n low): all outputs 0, except o_ready=1. State IDLE, latency counter 0.
- Reset mid-operation: the pending op is dropped. No request pulse is reissued and no o_valid is produced.
- States:
  - IDLE: o_ready=1. On i_valid, capture the op and go to REQ.
  - REQ: exactly one cycle; the request pulse is high here. Counter loads MEM_LAT-1. Go to WAIT if MEM_LAT>1, else DONE.
  - WAIT: decrement the counter; go to DONE when it reaches 0.
  - DONE: one cycle. At the exit edge sample i_d_data, register the result and o_valid=1, then go to IDLE.
- Timing: acceptance at edge E0. MemRead/MemWrite visible after E0 for exactly one cycle. o_valid visible after edge E(MEM_LAT+1) for exactly one cycle.
- i_valid is ignored when o_ready=0.
- A new op may be accepted in the cycle o_valid is high, giving a peak throughput of one op per MEM_LAT+2 cycles.
- Size handling:
  - Size from i_funct3; D is demoted to W when DATA_W=32.
  - Lane offset = i_addr[OFS_W-1:0]. Effective offset is rounded down to size alignment (macro off).
  - Request addresses = i_addr with the low OFS_W bits cleared. Unused address outputs are 0.
- Store:
  - o_d_w_strb has size-many ones shifted left by the offset.
  - o_d_w_data = i_data << (8*offset), zero-filled.
  - o_data = i_addr.
- Load:
  - Extract the lane from i_d_data >> (8*offset).
  - Signed sizes (B/H/W) sign-extend to DATA_W; BU/HU/WU zero-extend; D passes through.
- Pass-through (type 2/3): no MemRead/MemWrite pulse, o_d_w_strb=0, same latency, o_data = i_addr.
- o_rd_id, o_type and o_data hold their last values while o_valid=0.

Optional Feature:
- Macro: MEM_LSU_MISALIGN_TRAP_EN.
- Defined: if the offset is not a multiple of the access size for a load or store:
  - no request pulse and strobe 0;
  - op completes with normal latency;
  - o_misalign=1 with o_valid, o_data=i_addr.
- Undefined: o_misalign is tied to 0 and the access is aligned down as described above.

Test Plan:
- MEM_LAT=1, load LD addr 0x100, i_d_data=0x1122334455667788 -> MemRead pulse after E0 with r_addr 0x100; o_valid after E2 with o_data 0x1122334455667788, o_rd_id captured.
- MEM_LAT=3, load LB addr 0x103, byte lane 3 = 0x80 -> o_valid after E4 with o_data 0xFFFFFFFFFFFFFF80; LBU on the same data gives 0x80.
- Store SH addr 0x206, i_data 0xBEEF -> w_addr 0x200, strb 0xC0, w_data 0xBEEF000000000000, one MemWrite pulse, o_data 0x206.
- Pass-through type 2, i_addr 0x42 -> no MemRead/MemWrite, o_valid after E2 with o_data 0x42; i_valid held during the busy cycles is not accepted twice.
- Reset asserted during WAIT (MEM_LAT=4) -> all outputs 0 and o_ready=1 immediately; no o_valid afterwards.
- Macro on, LW addr 0x102 -> no MemRead, o_valid with o_misalign=1; macro off -> read at 0x100, word taken from lane 0.

Source files
------------

// File: rtl/mem_lsu_stage.sv
// Memory-access stage: one load/store/pass-through op in flight, fixed MEM_LAT memory latency.
// Optional macro MEM_LSU_MISALIGN_TRAP_EN flags misaligned accesses instead of aligning them down.
module mem_lsu_stage #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_W-1:0]     i_addr,
  input  logic [DATA_W-1:0]     i_data,
  input  logic [4:0]            i_rd_id,
  input  logic [1:0]            i_type,
  input  logic [2:0]            i_funct3,
  output logic [DATA_W-1:0]     o_data,
  output logic [4:0]            o_rd_id,
  output logic [1:0]            o_type,
  output logic                  o_valid,
  output logic                  o_misalign,
  output logic [ADDR_W-1:0]     o_d_r_addr,
  output logic [ADDR_W-1:0]     o_d_w_addr,
  output logic [DATA_W-1:0]     o_d_w_data,
  output logic [DATA_W/8-1:0]   o_d_w_strb,
  output logic                  o_d_MemRead,
  output logic                  o_d_MemWrite,
  input  logic [DATA_W-1:0]     i_d_data
);

  localparam int NB    = DATA_W / 8;
  localparam int OFS_W = $clog2(NB);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [1:0] T_LOAD  = 2'd0;
  localparam logic [1:0] T_STORE = 2'd1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  r_addr;
  logic [4:0]         r_rd_id;
  logic [1:0]         r_type;
  logic [1:0]         r_size;
  logic               r_unsigned;
  logic [OFS_W-1:0]   r_ofs;
  logic               r_trap;

  logic [1:0]         w_size;
  logic [OFS_W-1:0]   w_ofs;
  logic [OFS_W-1:0]   w_size_mask;
  logic [OFS_W-1:0]   w_eff_ofs;
  logic               w_is_ld;
  logic               w_is_st;
  logic               w_trap;
  logic               w_do_rd;
  logic               w_do_wr;
  logic [NB-1:0]      w_lanes;
  logic [NB-1:0]      w_strb;
  logic [DATA_W-1:0]  w_wdata;
  logic [ADDR_W-1:0]  w_req_addr;
  logic [DATA_W-1:0]  w_rshift;
  logic [DATA_W-1:0]  w_load;

  // Decode the incoming op: size, lane offset, strobes and lane-shifted store data.
  always_comb begin
    w_size = i_funct3[1:0];
    if (DATA_W == 32 && w_size == 2'd3) w_size = 2'd2;
    w_ofs   = i_addr[OFS_W-1:0];
    w_is_ld = (i_type == T_LOAD);
    w_is_st = (i_type == T_STORE);
    case (w_size)
      2'd0:    begin w_size_mask = '0;          w_lanes = NB'(1);  end
      2'd1:    begin w_size_mask = OFS_W'(1);   w_lanes = NB'(3);  end
      2'd2:    begin w_size_mask = OFS_W'(3);   w_lanes = NB'(15); end
      default: begin w_size_mask = OFS_W'(7);   w_lanes = '1;      end
    endcase
    w_eff_ofs  = w_ofs & ~w_size_mask;
    w_strb     = w_lanes << w_eff_ofs;
    w_wdata    = i_data << {w_eff_ofs, 3'b000};
    w_req_addr = ADDR_W'(i_addr);
    w_req_addr[OFS_W-1:0] = '0;
  end

`ifdef MEM_LSU_MISALIGN_TRAP_EN
  assign w_trap = (w_is_ld || w_is_st) && ((w_ofs & w_size_mask) != '0);
`else
  assign w_trap = 1'b0;
`endif

  assign w_do_rd = w_is_ld && !w_trap;
  assign w_do_wr = w_is_st && !w_trap;

  // Load lane extraction from the sampled read data.
  always_comb begin
    w_rshift = i_d_data >> {r_ofs, 3'b000};
    w_load   = w_rshift;
    case (r_size)
      2'd0: begin
        if (r_unsigned) w_load = DATA_W'(w_rshift[7:0]);
        else            w_load = DATA_W'($signed(w_rshift[7:0]));
      end
      2'd1: begin
        if (r_unsigned) w_load = DATA_W'(w_rshift[15:0]);
        else            w_load = DATA_W'($signed(w_rshift[15:0]));
      end
      2'd2: begin
        if (r_unsigned) w_load = DATA_W'(w_rshift[31:0]);
        else            w_load = DATA_W'($signed(w_rshift[31:0]));
      end
      default: w_load = w_rshift;
    endcase
  end

  // Sequencer: IDLE -> REQ -> (WAIT) -> DONE, all outputs registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_rd_id      <= '0;
      r_type       <= '0;
      r_size       <= '0;
      r_unsigned   <= 1'b0;
      r_ofs        <= '0;
      r_trap       <= 1'b0;
      o_ready      <= 1'b1;
      o_valid      <= 1'b0;
      o_misalign   <= 1'b0;
      o_data       <= '0;
      o_rd_id      <= '0;
      o_type       <= '0;
      o_d_r_addr   <= '0;
      o_d_w_addr   <= '0;
      o_d_w_data   <= '0;
      o_d_w_strb   <= '0;
      o_d_MemRead  <= 1'b0;
      o_d_MemWrite <= 1'b0;
    end else begin
      o_valid      <= 1'b0;
      o_misalign   <= 1'b0;
      o_d_MemRead  <= 1'b0;
      o_d_MemWrite <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_addr       <= i_addr;
            r_rd_id      <= i_rd_id;
            r_type       <= i_type;
            r_size       <= w_size;
            r_unsigned   <= i_funct3[2];
            r_ofs        <= w_eff_ofs;
            r_trap       <= w_trap;
            o_ready      <= 1'b0;
            o_d_MemRead  <= w_do_rd;
            o_d_MemWrite <= w_do_wr;
            o_d_r_addr   <= w_do_rd ? w_req_addr : '0;
            o_d_w_addr   <= w_do_wr ? w_req_addr : '0;
            o_d_w_data   <= w_do_wr ? w_wdata : '0;
            o_d_w_strb   <= w_do_wr ? w_strb : '0;
            r_state      <= S_REQ;
          end
        end
        S_REQ: begin
          r_cnt   <= CNT_W'(MEM_LAT - 1);
          r_state <= (MEM_LAT > 1) ? S_WAIT : S_DONE;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= S_DONE;
        end
        S_DONE: begin
          o_valid    <= 1'b1;
          o_misalign <= r_trap;
          o_data     <= (r_type == T_LOAD && !r_trap) ? w_load : r_addr;
          o_rd_id    <= r_rd_id;
          o_type     <= r_type;
          o_ready    <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
